// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA engine's CCI-P request paths.
// Includes the c1 write header layout and a helper that builds it from the arbiter outputs.
package dma_pkg;

    localparam int MDATA_REQ_ID_W = 3;
    localparam int CL_ADDR_W      = 42;
    localparam int CL_DATA_W      = 512;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4
    } t_c1_req;

    typedef enum logic [1:0] {
        eVC_VA  = 2'b00,
        eVC_VL0 = 2'b01,
        eVC_VH0 = 2'b10,
        eVC_VH1 = 2'b11
    } t_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_cl_len;

    typedef struct packed {
        logic                 fence;
        logic [CL_ADDR_W-1:0] addr;
        logic [CL_DATA_W-1:0] data;
    } t_wr_req;

    typedef struct packed {
        logic [5:0]           rsvd2;
        t_vc                  vc_sel;
        logic                 sop;
        logic                 rsvd1;
        t_cl_len              cl_len;
        t_c1_req              req_type;
        logic [5:0]           rsvd0;
        logic [CL_ADDR_W-1:0] address;
        logic [15:0]          mdata;
    } t_c1_hdr;

    function automatic t_c1_hdr build_c1_hdr(
        input logic                 is_fence,
        input logic [CL_ADDR_W-1:0] addr,
        input logic [15:0]          mdata
    );
        t_c1_hdr hdr;
        hdr          = '0;
        hdr.vc_sel   = eVC_VA;
        hdr.sop      = 1'b1;
        hdr.cl_len   = eCL_LEN_1;
        hdr.req_type = is_fence ? eREQ_WRFENCE : eREQ_WRLINE_I;
        hdr.address  = is_fence ? '0 : addr;
        hdr.mdata    = mdata;
        return hdr;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping mod N.
// Shared between the c1 write arbiter and the c0 read arbiter.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [N-1:0]   rot;
    logic [IDX_W:0] sum;
    logic [IDX_W:0] offs;
    logic           found;

    always_comb begin
        rot       = N'({eligible, eligible} >> ptr);
        found     = 1'b0;
        offs      = '0;
        grant     = '0;
        grant_idx = '0;
        // rot[0] is the pointer's own requester, so it has top priority
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                offs  = (IDX_W+1)'(k);
            end
        end
        sum = {1'b0, ptr} + offs;
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        if (found) begin
            grant_idx = sum[IDX_W-1:0];
        end
        for (int j = 0; j < N; j++) begin
            grant[j] = found && (grant_idx == IDX_W'(j));
        end
    end

endmodule

// File: rtl/c1_wr_arbiter.sv
// Round-robin arbiter for the CCI-P c1 write channel with per-requester outstanding tracking.
// Requester index travels in mdata[2:0] so responses can be credited back.
module c1_wr_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 64,
    parameter int ADDR_W          = 42
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_fence,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*512-1:0]    req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      c1TxAlmFull,
    output logic                      out_valid,
    output logic                      out_is_fence,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [511:0]              out_data,
    output logic [15:0]               out_mdata,
    input  logic                      rsp_valid,
    input  logic [15:0]               rsp_mdata,
    output logic [NUM_REQ-1:0]        idle,
    output logic                      err_rsp
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    t_wr_req                   req [NUM_REQ];
    t_wr_req                   sel_req;
    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      any_grant;
    logic [IDX_W-1:0]          ptr_reg;
    logic [IDX_W-1:0]          ptr_next;
    cnt_t                      cnt_reg  [NUM_REQ];
    cnt_t                      cnt_next [NUM_REQ];
    logic [NUM_REQ-1:0]        rsp_hit;
    logic [NUM_REQ-1:0]        rsp_dec;
    logic [NUM_REQ-1:0]        rsp_zero;
    logic [MDATA_REQ_ID_W-1:0] rsp_id;
    logic                      rsp_in_range;
    logic                      rsp_mdata_unused;

    logic                      out_valid_reg;
    logic                      out_is_fence_reg;
    logic [ADDR_W-1:0]         out_addr_reg;
    logic [511:0]              out_data_reg;
    logic [15:0]               out_mdata_reg;
    logic [NUM_REQ-1:0]        idle_reg;
    logic                      err_rsp_reg;
    logic                      err_rsp_next;

    assign rsp_id           = rsp_mdata[MDATA_REQ_ID_W-1:0];
    assign rsp_mdata_unused = ^rsp_mdata[15:MDATA_REQ_ID_W];
    assign rsp_in_range     = ({1'b0, rsp_id} < (MDATA_REQ_ID_W+1)'(NUM_REQ));

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req[gi] = '{
                fence: req_fence[gi],
                addr:  CL_ADDR_W'(req_addr[gi*ADDR_W +: ADDR_W]),
                data:  req_data[gi*512 +: 512]
            };
            assign eligible[gi] = req_valid[gi] && !c1TxAlmFull
                                  && (cnt_reg[gi] < cnt_t'(MAX_OUTSTANDING));
            assign rsp_hit[gi]  = rsp_valid && (rsp_id == MDATA_REQ_ID_W'(gi));
            assign rsp_dec[gi]  = rsp_hit[gi] && (cnt_reg[gi] != '0);
            assign rsp_zero[gi] = rsp_hit[gi] && (cnt_reg[gi] == '0);
            // a grant and a credited response in the same cycle cancel out
            assign cnt_next[gi] = (grant[gi] && !rsp_dec[gi]) ? cnt_reg[gi] + cnt_t'(1) :
                                  (!grant[gi] && rsp_dec[gi]) ? cnt_reg[gi] - cnt_t'(1) :
                                  cnt_reg[gi];
        end
    endgenerate

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .eligible  (eligible),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign any_grant    = |grant;
    assign sel_req      = req[grant_idx];
    assign req_ready    = grant;
    assign ptr_next     = !any_grant ? ptr_reg :
                          (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
    assign err_rsp_next = err_rsp_reg || (rsp_valid && !rsp_in_range) || (|rsp_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg          <= '0;
            out_valid_reg    <= 1'b0;
            out_is_fence_reg <= 1'b0;
            out_addr_reg     <= '0;
            out_data_reg     <= '0;
            out_mdata_reg    <= '0;
            idle_reg         <= '1;
            err_rsp_reg      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            ptr_reg       <= ptr_next;
            out_valid_reg <= any_grant;
            err_rsp_reg   <= err_rsp_next;
            if (any_grant) begin
                out_is_fence_reg <= sel_req.fence;
                out_addr_reg     <= sel_req.fence ? '0 : ADDR_W'(sel_req.addr);
                out_data_reg     <= sel_req.data;
                out_mdata_reg    <= 16'(grant_idx);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_reg[i]  <= cnt_next[i];
                idle_reg[i] <= (cnt_next[i] == '0);
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_is_fence = out_is_fence_reg;
    assign out_addr     = out_addr_reg;
    assign out_data     = out_data_reg;
    assign out_mdata    = out_mdata_reg;
    assign idle         = idle_reg;
    assign err_rsp      = err_rsp_reg;

endmodule

// File: tb/tb_c1_wr_arbiter.sv
// Directed bench for c1_wr_arbiter: a per-cycle vector table plus hand sequences for
// round-robin order, almost-full stall, outstanding cap and error response.
module tb_c1_wr_arbiter;

    localparam int NUM_REQ = 3;
    localparam int MAX_OUT = 64;
    localparam int ADDR_W  = 42;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_fence;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*512-1:0]    req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      c1TxAlmFull;
    logic                      out_valid;
    logic                      out_is_fence;
    logic [ADDR_W-1:0]         out_addr;
    logic [511:0]              out_data;
    logic [15:0]               out_mdata;
    logic                      rsp_valid;
    logic [15:0]               rsp_mdata;
    logic [NUM_REQ-1:0]        idle;
    logic                      err_rsp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    c1_wr_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .MAX_OUTSTANDING (MAX_OUT),
        .ADDR_W          (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_fence    (req_fence),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .c1TxAlmFull  (c1TxAlmFull),
        .out_valid    (out_valid),
        .out_is_fence (out_is_fence),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_mdata    (out_mdata),
        .rsp_valid    (rsp_valid),
        .rsp_mdata    (rsp_mdata),
        .idle         (idle),
        .err_rsp      (err_rsp)
    );

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return ADDR_W'(32'h100 * (i + 1));
    endfunction

    function automatic logic [511:0] data_of(input int i);
        logic [31:0] w;
        w = 32'hCAFE_0000 + 32'(i);
        return {16{w}};
    endfunction

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  fence;
        logic        alm;
        logic        rv;
        logic [2:0]  rid;
        logic [2:0]  e_ready;
        logic        e_ov;
        int          e_idx;
        logic        e_fence;
        logic [2:0]  e_idle;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] f, input logic a,
                                input logic rv, input logic [2:0] rid, input logic [2:0] er,
                                input logic eov, input int eidx, input logic ef,
                                input logic [2:0] eidle, input logic eerr);
        vec_t t;
        t.valid = v;   t.fence = f;    t.alm = a;      t.rv = rv;       t.rid = rid;
        t.e_ready = er; t.e_ov = eov;  t.e_idx = eidx; t.e_fence = ef;
        t.e_idle = eidle; t.e_err = eerr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] f, input logic a,
                         input logic rv, input logic [2:0] rid);
        req_valid   = v;
        req_fence   = f;
        c1TxAlmFull = a;
        rsp_valid   = rv;
        rsp_mdata   = {13'b0, rid};
    endtask

    // check combinational ready mid-cycle, then advance to just after the next edge
    task automatic step(input string name, input logic [2:0] exp_ready);
        #2;
        chk({name, " req_ready"}, 512'(req_ready), 512'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 3'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t vt [15];
    logic [2:0] rr_exp [6];

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
            req_data[i*512 +: 512]       = data_of(i);
        end

        //           valid   fence   alm   rv    rid   ready  ov    idx fence idle   err
        vt[0]  = mk(3'b001, 3'b000, 1'b0, 1'b0, 3'd0, 3'b001, 1'b1, 0, 1'b0, 3'b110, 1'b0);
        vt[1]  = mk(3'b000, 3'b000, 1'b0, 1'b1, 3'd0, 3'b000, 1'b0, 0, 1'b0, 3'b111, 1'b0);
        vt[2]  = mk(3'b111, 3'b000, 1'b0, 1'b0, 3'd0, 3'b010, 1'b1, 1, 1'b0, 3'b101, 1'b0);
        vt[3]  = mk(3'b111, 3'b000, 1'b0, 1'b0, 3'd0, 3'b100, 1'b1, 2, 1'b0, 3'b001, 1'b0);
        vt[4]  = mk(3'b111, 3'b000, 1'b0, 1'b0, 3'd0, 3'b001, 1'b1, 0, 1'b0, 3'b000, 1'b0);
        vt[5]  = mk(3'b111, 3'b000, 1'b1, 1'b0, 3'd0, 3'b000, 1'b0, 0, 1'b0, 3'b000, 1'b0);
        vt[6]  = mk(3'b100, 3'b100, 1'b0, 1'b0, 3'd0, 3'b100, 1'b1, 2, 1'b1, 3'b000, 1'b0);
        vt[7]  = mk(3'b100, 3'b100, 1'b0, 1'b1, 3'd2, 3'b100, 1'b1, 2, 1'b1, 3'b000, 1'b0);
        vt[8]  = mk(3'b000, 3'b000, 1'b0, 1'b1, 3'd5, 3'b000, 1'b0, 0, 1'b0, 3'b000, 1'b1);
        vt[9]  = mk(3'b010, 3'b000, 1'b0, 1'b1, 3'd1, 3'b010, 1'b1, 1, 1'b0, 3'b000, 1'b1);
        vt[10] = mk(3'b000, 3'b000, 1'b0, 1'b1, 3'd0, 3'b000, 1'b0, 0, 1'b0, 3'b001, 1'b1);
        vt[11] = mk(3'b000, 3'b000, 1'b0, 1'b1, 3'd1, 3'b000, 1'b0, 0, 1'b0, 3'b011, 1'b1);
        vt[12] = mk(3'b000, 3'b000, 1'b0, 1'b1, 3'd2, 3'b000, 1'b0, 0, 1'b0, 3'b011, 1'b1);
        vt[13] = mk(3'b000, 3'b000, 1'b0, 1'b1, 3'd2, 3'b000, 1'b0, 0, 1'b0, 3'b111, 1'b1);
        vt[14] = mk(3'b000, 3'b000, 1'b0, 1'b1, 3'd0, 3'b000, 1'b0, 0, 1'b0, 3'b111, 1'b1);

        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

        do_reset();
        chk("reset out_valid", 512'(out_valid), 512'(0));
        chk("reset out_is_fence", 512'(out_is_fence), 512'(0));
        chk("reset out_addr", 512'(out_addr), 512'(0));
        chk("reset out_data", out_data, 512'(0));
        chk("reset out_mdata", 512'(out_mdata), 512'(0));
        chk("reset idle", 512'(idle), 512'(3'b111));
        chk("reset err_rsp", 512'(err_rsp), 512'(0));

        for (int v = 0; v < 15; v++) begin
            drive(vt[v].valid, vt[v].fence, vt[v].alm, vt[v].rv, vt[v].rid);
            step($sformatf("vec%0d", v), vt[v].e_ready);
            chk($sformatf("vec%0d out_valid", v), 512'(out_valid), 512'(vt[v].e_ov));
            if (vt[v].e_ov) begin
                chk($sformatf("vec%0d out_mdata", v), 512'(out_mdata), 512'(vt[v].e_idx));
                chk($sformatf("vec%0d out_is_fence", v), 512'(out_is_fence), 512'(vt[v].e_fence));
                chk($sformatf("vec%0d out_addr", v), 512'(out_addr),
                    512'(vt[v].e_fence ? '0 : addr_of(vt[v].e_idx)));
                if (!vt[v].e_fence)
                    chk($sformatf("vec%0d out_data", v), out_data, data_of(vt[v].e_idx));
            end
            chk($sformatf("vec%0d idle", v), 512'(idle), 512'(vt[v].e_idle));
            chk($sformatf("vec%0d err_rsp", v), 512'(err_rsp), 512'(vt[v].e_err));
            $display("vec%0d: valid=%b ready=%b out_valid=%b mdata=%0d idle=%b err=%b",
                     v, vt[v].valid, req_ready, out_valid, out_mdata, idle, err_rsp);
        end

        // Response for an idle requester: sticky error, count must stay at zero
        do_reset();
        chk("post-table reset err_rsp", 512'(err_rsp), 512'(0));
        drive(3'b000, 3'b000, 1'b0, 1'b1, 3'd0);
        step("zero rsp", 3'b000);
        chk("zero rsp err_rsp", 512'(err_rsp), 512'(1));
        chk("zero rsp idle", 512'(idle), 512'(3'b111));
        drive(3'b000, 3'b000, 1'b0, 1'b0, 3'd0);
        step("err hold", 3'b000);
        step("err hold", 3'b000);
        chk("err sticky", 512'(err_rsp), 512'(1));
        drive(3'b001, 3'b000, 1'b0, 1'b0, 3'd0);
        step("write after err", 3'b001);
        chk("write after err idle", 512'(idle), 512'(3'b110));
        drive(3'b000, 3'b000, 1'b0, 1'b1, 3'd0);
        step("rsp after err", 3'b000);
        chk("rsp after err idle", 512'(idle), 512'(3'b111));
        $display("err seq: err=%b idle=%b", err_rsp, idle);
        do_reset();
        chk("err cleared by reset", 512'(err_rsp), 512'(0));

        // Round-robin order from pointer 0 with all requesters valid
        for (int k = 0; k < 6; k++) begin
            drive(3'b111, 3'b000, 1'b0, 1'b0, 3'd0);
            step($sformatf("rr%0d", k), rr_exp[k]);
            chk($sformatf("rr%0d out_mdata", k), 512'(out_mdata), 512'(k % 3));
            $display("rr%0d: ready=%b mdata=%0d", k, req_ready, out_mdata);
        end
        for (int k = 0; k < 6; k++) begin
            drive(3'b000, 3'b000, 1'b0, 1'b1, 3'(k % 3));
            step($sformatf("rr drain%0d", k), 3'b000);
        end
        chk("rr drained idle", 512'(idle), 512'(3'b111));

        // Almost-full blocks all grants; grant resumes the cycle it drops
        for (int k = 0; k < 5; k++) begin
            drive(3'b111, 3'b000, 1'b1, 1'b0, 3'd0);
            step($sformatf("almfull%0d", k), 3'b000);
            chk($sformatf("almfull%0d out_valid", k), 512'(out_valid), 512'(0));
            $display("almfull%0d: ready=%b out_valid=%b", k, req_ready, out_valid);
        end
        drive(3'b111, 3'b000, 1'b0, 1'b0, 3'd0);
        step("almfull release", 3'b001);
        chk("almfull release out_valid", 512'(out_valid), 512'(1));
        chk("almfull release out_mdata", 512'(out_mdata), 512'(0));

        // Requester 1 fills its outstanding window; others keep being served
        for (int k = 0; k < MAX_OUT; k++) begin
            drive(3'b010, 3'b000, 1'b0, 1'b0, 3'd0);
            step($sformatf("fill%0d", k), 3'b010);
        end
        $display("fill: 64 writes from requester 1 issued, idle=%b", idle);
        drive(3'b111, 3'b000, 1'b0, 1'b0, 3'd0);
        step("cap0", 3'b100);
        step("cap1", 3'b001);
        step("cap2", 3'b100);
        step("cap3", 3'b001);
        drive(3'b010, 3'b000, 1'b0, 1'b1, 3'd1);
        step("cap rsp", 3'b000);
        drive(3'b010, 3'b000, 1'b0, 1'b0, 3'd0);
        step("cap resume", 3'b010);
        chk("cap resume out_mdata", 512'(out_mdata), 512'(1));
        $display("cap: requester 1 resumed, out_mdata=%0d", out_mdata);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
